data_mem_responder: RTL

//  Memory-side responder for the core's data-memory port. Services word loads/stores
//  (data_address/MemRead/MemWrite/size) and 256-bit block reads/writes (dBlkRead/dBlkWrite),

---
 rtl/data_mem_responder_pkg.sv | 38 +++
 rtl/data_mem_responder_if.sv | 29 ++
 rtl/data_mem_responder_mem_block_array.sv | 46 ++++
 rtl/data_mem_responder.sv | 101 ++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types, constants and byte-lane helpers for the data-memory responder.
// Lane numbering: lane 3 = bits [31:24] = lowest byte address (big-endian).
package data_mem_pkg;

  localparam int unsigned BLOCK_BITS      = 256;
  localparam int unsigned WORDS_PER_BLOCK = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    WAIT_DROP
  } blk_state_e;

  localparam logic [1:0] SZ_1 = 2'd1;
  localparam logic [1:0] SZ_2 = 2'd2;
  localparam logic [1:0] SZ_3 = 2'd3;
  localparam logic [1:0] SZ_4 = 2'd0;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    size_bytes = (size == SZ_4) ? 3'd4 : {1'b0, size};
  endfunction

  // Bytes past the word boundary fall off the right end of the shift.
  function automatic logic [3:0] byte_mask(input logic [1:0] addr_lo, input logic [1:0] size);
    logic [3:0] w_top;
    w_top     = 4'b1111 << (3'd4 - size_bytes(size));
    byte_mask = w_top >> addr_lo;
  endfunction

  function automatic logic [31:0] align_wdata(input logic [1:0] addr_lo, input logic [1:0] size,
                                              input logic [31:0] data);
    logic [63:0] w_wide;
    w_wide      = {data, 32'h0} >> (8 * (32'(addr_lo) + 32'(size_bytes(size))));
    align_wdata = w_wide[31:0];
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-memory data port: word load/store and 256-bit block transfer signals.
interface data_mem_responder_if;
  import data_mem_pkg::*;

  logic [31:0]           data_address_2DM;
  logic                  MemRead_2DM;
  logic                  MemWrite_2DM;
  logic [31:0]           data_write_2DM;
  logic [1:0]            data_write_size_2DM;
  logic [31:0]           data_read_fDM;
  logic                  dBlkRead;
  logic                  dBlkWrite;
  logic [BLOCK_BITS-1:0] block_write_2DM;
  logic [BLOCK_BITS-1:0] block_read_fDM;
  logic                  block_read_fDM_valid;
  logic                  block_write_fDM_valid;

  modport master (
    output data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM, data_write_size_2DM,
    output dBlkRead, dBlkWrite, block_write_2DM,
    input  data_read_fDM, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
  );

  modport slave (
    input  data_address_2DM, MemRead_2DM, MemWrite_2DM, data_write_2DM, data_write_size_2DM,
    input  dBlkRead, dBlkWrite, block_write_2DM,
    output data_read_fDM, block_read_fDM, block_read_fDM_valid, block_write_fDM_valid
  );
endinterface

// File: rtl/data_mem_responder_mem_block_array.sv
// Block-organised storage: async word read, byte-enabled word write, full-block port.
// Storage is intentionally not reset.
module mem_block_array
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                  i_clk,
  input  logic [ADDR_BITS-3:0]  i_word_idx,
  output logic [31:0]           o_word_rdata,
  input  logic                  i_word_we,
  input  logic [3:0]            i_word_be,
  input  logic [31:0]           i_word_wdata,
  input  logic [ADDR_BITS-6:0]  i_blk_idx,
  output logic [BLOCK_BITS-1:0] o_blk_rdata,
  input  logic                  i_blk_we,
  input  logic [BLOCK_BITS-1:0] i_blk_wdata
);

  localparam int unsigned NBLK = 1 << (ADDR_BITS - 5);

  logic [BLOCK_BITS-1:0] r_mem [NBLK];
  logic [ADDR_BITS-6:0]  w_word_blk;
  logic [2:0]            w_wsel;
  logic [BLOCK_BITS-1:0] w_word_line;
  logic                  w_word_blocked;

  assign w_word_blk     = i_word_idx[ADDR_BITS-3:3];
  assign w_wsel         = i_word_idx[2:0];
  assign w_word_line    = r_mem[w_word_blk];
  assign o_word_rdata   = w_word_line[32 * (7 - 32'(w_wsel)) +: 32];
  assign o_blk_rdata    = r_mem[i_blk_idx];
  // A block commit owns its whole block for that edge.
  assign w_word_blocked = i_blk_we && (i_blk_idx == w_word_blk);

  always_ff @(posedge i_clk) begin
    if (i_blk_we) r_mem[i_blk_idx] <= i_blk_wdata;
    if (i_word_we && !w_word_blocked) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_word_be[b])
          r_mem[w_word_blk][32 * (7 - 32'(w_wsel)) + 8 * b +: 8] <= i_word_wdata[8 * b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: zero-wait word path plus latency-modelled block read/write FSM.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 16,
  parameter int unsigned BLK_LATENCY = 4
) (
  input  logic          CLK,
  input  logic          RESET,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IDX_BITS = ADDR_BITS - 5;
  localparam logic [7:0]  CNT_LOAD = 8'(BLK_LATENCY - 1);

  blk_state_e            r_state, w_state_nxt;
  logic                  r_op_wr, w_op_wr_nxt;
  logic [IDX_BITS-1:0]   r_blk_idx, w_blk_idx_nxt;
  logic [7:0]            r_cnt, w_cnt_nxt;
  logic [BLOCK_BITS-1:0] r_blk_hold;

  logic                  w_req_held;
  logic                  w_rd_done;
  logic                  w_wr_done;
  logic [31:0]           w_word_rdata;
  logic [BLOCK_BITS-1:0] w_blk_rdata;
  logic                  w_unused_addr;

  assign w_unused_addr = ^bus.data_address_2DM[31:ADDR_BITS];
  assign w_req_held    = r_op_wr ? bus.dBlkWrite : bus.dBlkRead;
  assign w_rd_done     = (r_state == DONE) && !r_op_wr;
  assign w_wr_done     = (r_state == DONE) && r_op_wr;

  assign bus.data_read_fDM         = bus.MemRead_2DM ? w_word_rdata : '0;
  assign bus.block_read_fDM_valid  = w_rd_done;
  assign bus.block_write_fDM_valid = w_wr_done;
  assign bus.block_read_fDM        = w_rd_done ? w_blk_rdata : r_blk_hold;

  // DONE is entered on the edge where cnt reaches 0, so acceptance-to-valid spans
  // BLK_LATENCY-1 edges; a latency of 1 skips BUSY entirely.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_wr_nxt   = r_op_wr;
    w_blk_idx_nxt = r_blk_idx;
    w_cnt_nxt     = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.dBlkWrite || bus.dBlkRead) begin
          w_op_wr_nxt   = bus.dBlkWrite;
          w_blk_idx_nxt = bus.data_address_2DM[ADDR_BITS-1:5];
          w_cnt_nxt     = CNT_LOAD;
          w_state_nxt   = (BLK_LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (!w_req_held) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == 8'd1) begin
          w_cnt_nxt   = '0;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      DONE:      w_state_nxt = WAIT_DROP;
      WAIT_DROP: if (!bus.dBlkWrite && !bus.dBlkRead) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_op_wr    <= 1'b0;
      r_blk_idx  <= '0;
      r_cnt      <= '0;
      r_blk_hold <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_op_wr   <= w_op_wr_nxt;
      r_blk_idx <= w_blk_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      if (w_rd_done) r_blk_hold <= w_blk_rdata;
    end
  end

  mem_block_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .i_clk        (CLK),
    .i_word_idx   (bus.data_address_2DM[ADDR_BITS-1:2]),
    .o_word_rdata (w_word_rdata),
    .i_word_we    (bus.MemWrite_2DM),
    .i_word_be    (byte_mask(bus.data_address_2DM[1:0], bus.data_write_size_2DM)),
    .i_word_wdata (align_wdata(bus.data_address_2DM[1:0], bus.data_write_size_2DM,
                               bus.data_write_2DM)),
    .i_blk_idx    (r_blk_idx),
    .o_blk_rdata  (w_blk_rdata),
    .i_blk_we     (w_wr_done),
    .i_blk_wdata  (bus.block_write_2DM)
  );

endmodule
